// File: rtl/mac_psum_sequencer_if.sv
// rtl/mac_psum_sequencer_if.sv - start/MAC/result bundle between a requester and the psum sequencer
interface mac_psum_sequencer_if #(
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int OUTPUT_WIDTH      = 16,
  parameter int DEPTH             = 16
);
  logic                         start_valid;
  logic                         start_ready;
  logic                         first_in;
  logic                         last_in;
  logic                         input_valid_1;
  logic                         input_valid_2;
  logic                         input_valid_3;
  logic [ACCUMULATOR_WIDTH-1:0] fifo_out;
  logic [OUTPUT_WIDTH-1:0]      mac_out;
  logic                         result_valid;
  logic                         result_ready;
  logic [OUTPUT_WIDTH-1:0]      result_data;
  logic [$clog2(DEPTH):0]       psum_count;

  modport master (
    output start_valid, first_in, last_in, mac_out, result_ready,
    input  start_ready, input_valid_1, input_valid_2, input_valid_3,
    input  fifo_out, result_valid, result_data, psum_count
  );

  modport slave (
    input  start_valid, first_in, last_in, mac_out, result_ready,
    output start_ready, input_valid_1, input_valid_2, input_valid_3,
    output fifo_out, result_valid, result_data, psum_count
  );
endinterface

// File: rtl/mac_psum_sequencer.sv
// rtl/mac_psum_sequencer.sv - sequences 3-phase MAC operations around a partial-sum FIFO
module mac_psum_sequencer #(
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int OUTPUT_WIDTH      = 16,
  parameter int DEPTH             = 16
) (
  input logic                 clk,
  input logic                 rst_in,
  mac_psum_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, RES} state_t;

  state_t                       state, state_next;
  logic                         first_q, last_q;
  logic [PW-1:0]                rd_ptr, wr_ptr;
  logic [CW-1:0]                count;
  logic [ACCUMULATOR_WIDTH-1:0] mem [DEPTH];
  logic [OUTPUT_WIDTH-1:0]      result_q;
  logic                         start_ready_c;
  logic                         accept, pop, push, finish;
  logic [ACCUMULATOR_WIDTH-1:0] mac_ext;

  assign mac_ext = ACCUMULATOR_WIDTH'($signed(bus.mac_out));

  always_ff @(posedge clk) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Admission refuses ops that would pop an empty FIFO or push into a full one.
  always_comb begin
    state_next    = state;
    start_ready_c = 1'b0;
    accept        = 1'b0;
    pop           = 1'b0;
    push          = 1'b0;
    finish        = 1'b0;
    case (state)
      IDLE: begin
        start_ready_c = !(!bus.first_in && count == '0) &&
                        !(bus.first_in && !bus.last_in && count == CW'(DEPTH));
        accept = bus.start_valid && start_ready_c;
        if (accept) state_next = PH1;
      end
      PH1: begin
        pop        = !first_q;
        state_next = PH2;
      end
      PH2: state_next = PH3;
      PH3: begin
        push       = !last_q;
        finish     = last_q;
        state_next = last_q ? RES : IDLE;
      end
      RES: if (bus.result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        first_q <= bus.first_in;
        last_q  <= bus.last_in;
      end
      if (pop)    rd_ptr   <= rd_ptr + 1'b1;
      if (push)   wr_ptr   <= wr_ptr + 1'b1;
      if (finish) result_q <= bus.mac_out;
      // pop and push of one operation are two cycles apart, never simultaneous
      if (push)     count <= count + 1'b1;
      else if (pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in && push) mem[wr_ptr] <= mac_ext;
  end

  assign bus.start_ready   = start_ready_c;
  assign bus.input_valid_1 = (state == PH1);
  assign bus.input_valid_2 = (state == PH2);
  assign bus.input_valid_3 = (state == PH3);
  assign bus.fifo_out      = pop ? mem[rd_ptr] : '0;
  assign bus.result_valid  = (state == RES);
  assign bus.result_data   = result_q;
  assign bus.psum_count    = count;
endmodule

// File: tb/tb_mac_psum_sequencer.sv
// tb/tb_mac_psum_sequencer.sv - randomized and directed bench for mac_psum_sequencer
module tb_mac_psum_sequencer;
  logic clk = 1'b0;
  logic rst_in;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  mac_psum_sequencer_if bus ();
  mac_psum_sequencer dut (.clk(clk), .rst_in(rst_in), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] sext(input logic [15:0] v);
    int s;
    s = int'(v);
    if (s >= 32768) s = s - 65536;
    return 32'(s);
  endfunction

  function automatic bit can_start(input bit f, input bit l);
    if (!f && q.size() == 0) return 1'b0;
    if (f && !l && q.size() == 16) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [2:0] strobes();
    return {bus.input_valid_1, bus.input_valid_2, bus.input_valid_3};
  endfunction

  // One full operation; start_valid stays high throughout to show it is ignored
  task automatic do_op(input bit f, input bit l, input logic [15:0] mv, input int hold);
    logic [31:0] exp_fifo;
    bus.start_valid = 1'b1; bus.first_in = f; bus.last_in = l;
    #1;
    check("start_ready_idle", bus.start_ready, 1'b1);
    @(posedge clk); #1;
    exp_fifo = f ? 32'h0 : q[0];
    bus.first_in = 1'($urandom); bus.last_in = 1'($urandom);
    #1;
    check("ph1_strobes", strobes(), 3'b100);
    check("ph1_fifo_out", bus.fifo_out, exp_fifo);
    check("ph1_start_ready", bus.start_ready, 1'b0);
    if (!f) void'(q.pop_front());
    @(posedge clk); #1;
    check("ph2_strobes", strobes(), 3'b010);
    check("ph2_fifo_out", bus.fifo_out, 32'h0);
    check("ph2_count", bus.psum_count, q.size());
    @(posedge clk); #1;
    bus.mac_out = mv;
    check("ph3_strobes", strobes(), 3'b001);
    @(posedge clk); #1;
    bus.mac_out = 16'($urandom);
    if (!l) begin
      q.push_back(sext(mv));
      check("post_push_strobes", strobes(), 3'b000);
      check("post_push_count", bus.psum_count, q.size());
      check("post_push_no_result", bus.result_valid, 1'b0);
    end else begin
      check("res_valid", bus.result_valid, 1'b1);
      check("res_data", bus.result_data, mv);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        bus.mac_out = 16'($urandom);
        check("hold_valid", bus.result_valid, 1'b1);
        check("hold_data", bus.result_data, mv);
        check("hold_start_ready", bus.start_ready, 1'b0);
      end
      bus.result_ready = 1'b1;
      @(posedge clk); #1;
      bus.result_ready = 1'b0;
      check("res_done", bus.result_valid, 1'b0);
    end
    bus.start_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    @(posedge clk); #1;
    rst_in = 1'b0;
    q.delete();
  endtask

  initial begin
    bit f, l;
    logic [15:0] mv;
    rst_in = 1'b1;
    bus.start_valid = 1'b0; bus.first_in = 1'b1; bus.last_in = 1'b0;
    bus.mac_out = '0; bus.result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
    #1;
    check("rst_count", bus.psum_count, 0);
    check("rst_strobes", strobes(), 3'b000);
    check("rst_result_valid", bus.result_valid, 1'b0);
    check("rst_result_data", bus.result_data, 16'h0);
    check("rst_fifo_out", bus.fifo_out, 32'h0);
    check("rst_start_ready", bus.start_ready, 1'b1);

    do_op(1'b1, 1'b0, 16'hFFF6, 0);
    check("first_push_count", bus.psum_count, 1);
    do_op(1'b0, 1'b1, 16'h0025, 5);
    check("after_pop_count", bus.psum_count, 0);

    bus.start_valid = 1'b1; bus.first_in = 1'b0; bus.last_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("empty_start_ready", bus.start_ready, 1'b0);
      check("empty_strobes", strobes(), 3'b000);
      @(posedge clk); #1;
    end
    bus.start_valid = 1'b0;

    for (int i = 1; i <= 16; i++) do_op(1'b1, 1'b0, 16'(i), 0);
    check("full_count", bus.psum_count, 16);
    bus.first_in = 1'b1; bus.last_in = 1'b0; #1;
    check("full_refuse_push", bus.start_ready, 1'b0);
    bus.first_in = 1'b1; bus.last_in = 1'b1; #1;
    check("full_allow_passthru", bus.start_ready, 1'b1);
    bus.first_in = 1'b0; bus.last_in = 1'b0; #1;
    check("full_allow_pop", bus.start_ready, 1'b1);
    for (int i = 1; i <= 16; i++) do_op(1'b0, 1'b1, 16'($urandom), $urandom_range(0, 2));

    for (int n = 0; n < 40; n++) begin
      f  = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
      l  = 1'($urandom);
      mv = 16'($urandom);
      if (q.size() > 0 && $urandom_range(0, 2) == 0) f = 1'b0;
      if (can_start(f, l)) begin
        do_op(f, l, mv, $urandom_range(0, 2));
      end else begin
        bus.start_valid = 1'b1; bus.first_in = f; bus.last_in = l; #1;
        check("rand_refuse", bus.start_ready, 1'b0);
        @(posedge clk); #1;
        check("rand_refuse_strobes", strobes(), 3'b000);
        bus.start_valid = 1'b0;
      end
    end

    do_reset();
    #1;
    check("rst2_count", bus.psum_count, 0);
    for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 16'(100 + i), 0);
    check("pre_abort_count", bus.psum_count, 3);
    bus.start_valid = 1'b1; bus.first_in = 1'b0; bus.last_in = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    check("abort_ph1_fifo_out", bus.fifo_out, 32'd100);
    @(posedge clk); #1;
    check("abort_ph2_strobes", strobes(), 3'b010);
    check("abort_ph2_count", bus.psum_count, 2);
    do_reset();
    #1;
    check("abort_strobes", strobes(), 3'b000);
    check("abort_count", bus.psum_count, 0);
    check("abort_result_data", bus.result_data, 16'h0);
    check("abort_fifo_out", bus.fifo_out, 32'h0);
    bus.first_in = 1'b0; #1;
    check("abort_idle_empty", bus.start_ready, 1'b0);
    bus.first_in = 1'b1; #1;
    check("abort_idle", bus.start_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_result", bus.result_valid, 1'b0);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mac_psum_sequencer.md
MAC_PSUM_SEQUENCER -- requirements
Module: mac_psum_sequencer

Interface
REQ-001 Parameter ACCUMULATOR_WIDTH, default 32: width of partial sums stored and driven to the MAC.
REQ-002 Parameter OUTPUT_WIDTH, default 16: width of the MAC result consumed.
REQ-003 Parameter DEPTH, default 16: partial-sum FIFO entries; power of 2, >= 2.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_in  in  1  synchronous reset, active-high.
REQ-007 start_valid  in  1  request to launch one 3-phase MAC operation.
REQ-008 start_ready  out  1  operation accepted when start_valid && start_ready at a rising edge.
REQ-009 first_in  in  1  sampled at accept; 1 = no prior partial sum (MAC gets zero, no FIFO pop).
REQ-010 last_in  in  1  sampled at accept; 1 = result goes to the result port, not the FIFO.
REQ-011 input_valid_1 / input_valid_2 / input_valid_3  out  1 each  MAC phase strobes, one-hot or all zero.
REQ-012 fifo_out  out  ACCUMULATOR_WIDTH  signed partial sum presented to the MAC.
REQ-013 mac_out  in  OUTPUT_WIDTH  signed MAC result, valid combinationally during phase 3.
REQ-014 result_valid / result_ready  out / in  1 each  final-result handshake.
REQ-015 result_data  out  OUTPUT_WIDTH  registered final result.
REQ-016 psum_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 FSM states SHALL be IDLE, PH1, PH2, PH3, RES.
- IDLE->PH1 on accept.
- PH1->PH2->PH3 unconditionally, one cycle each.
- PH3->RES if last, else IDLE.
- RES->IDLE on result_valid && result_ready.
REQ-018 input_valid_1 SHALL be 1 only in PH1, input_valid_2 only in PH2, input_valid_3 only in PH3.
REQ-019 start_ready SHALL be 1 only in IDLE, and not when (!first_in && psum_count==0), nor when (first_in && !last_in && psum_count==DEPTH).
- start_ready SHALL depend combinationally on first_in and last_in.
REQ-020 In PH1, fifo_out SHALL equal the FIFO head when first=0, else 0; fifo_out SHALL be 0 in all other states.
REQ-021 FIFO pop: at the end of PH1 when first=0; read pointer advances modulo DEPTH.
REQ-022 FIFO push: at the end of PH3 when last=0; writes sign-extended mac_out to ACCUMULATOR_WIDTH; write pointer advances modulo DEPTH.
REQ-023 psum_count SHALL be +1 on push, -1 on pop, and never exceed DEPTH or go below 0.
- Pop and push of one operation occur in different cycles.
REQ-024 At the end of PH3 when last=1, result_data SHALL capture mac_out; result_valid SHALL be 1 throughout RES.
- result_data SHALL hold stable until the handshake completes.
REQ-025 Latency: accept at edge T gives PH1 in cycle T+1, PH3 in cycle T+3, result_valid in cycle T+4.
- Minimum accept-to-accept spacing SHALL be 4 cycles for non-last operations.
REQ-026 start_valid SHALL be ignored outside IDLE; first/last SHALL be latched at accept only.
REQ-027 Pointers SHALL wrap-around from DEPTH-1 to 0 with no gap; FIFO order SHALL be strict FIFO.
REQ-028 No arithmetic SHALL be performed beyond sign extension; no saturation.

Reset
REQ-029 With rst_in high at an edge:
- state SHALL become IDLE;
- pointers and psum_count SHALL become 0;
- result_valid, result_data, all input_valid_* and fifo_out SHALL become 0.
REQ-030 Reset mid-operation SHALL abort the operation with no push, no pop and no result; FIFO contents are discarded.
REQ-031 FIFO memory contents need no reset.

Verification
REQ-032 Accept first=1,last=0; mac_out=16'hFFF6 in PH3 -> strobes 1,2,3 in cycles T+1..T+3, fifo_out=0 in PH1, psum_count=1, stored entry 32'hFFFFFFF6.
REQ-033 Then accept first=0,last=1; mac_out=16'h0025 -> fifo_out=32'hFFFFFFF6 in PH1, psum_count=0 after PH1, result_valid=1 at T+4 with result_data=16'h0025.
REQ-034 Hold result_ready=0 for 5 cycles -> result_valid and result_data stable, start_ready=0; result_ready=1 -> IDLE next cycle.
REQ-035 Fill to DEPTH=16 with values 1..16 -> start_ready=0 for first=1,last=0; later pops (first=0,last=1) return 1..16 in order across pointer wrap.
REQ-036 psum_count=0 with first=0 and start_valid=1 -> start_ready=0, no strobes.
REQ-037 rst_in in PH2 of a pop operation with count=3 -> next cycle IDLE, count=0, all strobes 0, no result_valid.
